// File: rtl/dot_product_accumulator.sv
// Sums K consecutive 8-bit products into one dot product and holds it on a valid/ready port.
// Optional DOT_ACC_FLUSH_EN adds a flush input that discards a partial sum.

// state | meaning
// ACCUM | accepting products, acc/cnt hold the partial sum
// HOLD  | finished sum on out_data, waiting for out_ready
module dot_product_accumulator #(
  parameter int K     = 4,
  parameter int ACC_W = 10,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] term_idx,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DOT_ACC_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_sum;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] out_data_nxt;
  logic             out_valid_nxt;
  logic             flush_i;
  logic             accept;

`ifdef DOT_ACC_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // in_ready depends only on state, rst and flush, never on in_valid
  assign in_ready = (state == ACCUM) && !rst && !flush_i;
  assign accept   = in_valid && in_ready;
  assign term_idx = cnt;
  assign acc_sum  = acc + ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    case (state)
      ACCUM: begin
        if (flush_i) begin
          acc_nxt = '0;
          cnt_nxt = '0;
        end else if (accept) begin
          if (cnt == LAST) begin
            out_data_nxt  = acc_sum;
            out_valid_nxt = 1'b1;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            state_nxt     = HOLD;
          end else begin
            acc_nxt = acc_sum;
            cnt_nxt = cnt + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: K=4 instance with a result scoreboard, plus a K=1 instance.
module tb_dot_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] prod;
  logic       in_valid, in_ready, out_valid, out_ready, flush;
  logic [1:0] term_idx;
  logic [9:0] out_data;

  logic [7:0] prod1;
  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0] term_idx1;
  logic [7:0] out_data1;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  dot_product_accumulator #(.K(4), .ACC_W(10), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_ready(in_ready),
    .term_idx(term_idx), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DOT_ACC_FLUSH_EN
    , .flush(flush)
`endif
  );

  dot_product_accumulator #(.K(1), .ACC_W(8), .IDX_W(1)) dut_k1 (
    .clk(clk), .rst(rst), .prod(prod1), .in_valid(in_valid1), .in_ready(in_ready1),
    .term_idx(term_idx1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef DOT_ACC_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // output handshake monitor: compare against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else chk("dot_sum", out_data, sb.pop_front());
    end
  end

  task automatic feed(input logic [7:0] p, input int idx);
    int n;
    prod = p;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else chk("term_idx", term_idx, idx);
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; prod = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    prod1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_term_idx", term_idx, 0);
    cycles(2);
    rst = 1'b0;

    // 4 x 225 = 900, consumed immediately
    out_ready = 1'b1;
    sb.push_back(10'd900);
    for (int i = 0; i < 4; i++) feed(8'd225, i);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready_hold", in_ready, 0);
    chk("t1_term_wrap", term_idx, 0);
    @(negedge clk);
    chk("t1_valid_one_cycle", out_valid, 0);
    @(posedge clk) #1;

    // held result under backpressure, pending 9 must not be consumed
    out_ready = 1'b0;
    sb.push_back(10'd10);
    feed(8'd1, 0); feed(8'd2, 1); feed(8'd3, 2); feed(8'd4, 3);
    prod = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_data", out_data, 10);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_in_ready", in_ready, 0);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    sb.push_back(10'd12);
    feed(8'd9, 0); feed(8'd1, 1); feed(8'd1, 2); feed(8'd1, 3);
    cycles(2);

    // idle gaps between products
    sb.push_back(10'd30);
    begin
      logic [7:0] seq [4];
      seq = '{8'd7, 8'd0, 8'd15, 8'd8};
      for (int i = 0; i < 4; i++) begin
        cycles($urandom_range(0, 3));
        feed(seq[i], i);
      end
    end
    cycles(2);

    // reset mid-sum discards the partial accumulation
    feed(8'd5, 0); feed(8'd6, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_term_idx", term_idx, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    sb.push_back(10'd4);
    for (int i = 0; i < 4; i++) feed(8'd1, i);
    cycles(2);

    // K=1: straight to HOLD, back-to-back product waits for the handshake
    prod1 = 8'd200; in_valid1 = 1'b1;
    @(negedge clk);
    chk("k1_in_ready", in_ready1, 1);
    @(posedge clk) #1;
    prod1 = 8'd100;
    @(negedge clk);
    chk("k1_out_valid", out_valid1, 1);
    chk("k1_out_data", out_data1, 200);
    chk("k1_in_ready_hold", in_ready1, 0);
    @(posedge clk) #1;
    out_ready1 = 1'b1;
    @(negedge clk);
    chk("k1_still_hold", in_ready1, 0);
    chk("k1_data_kept", out_data1, 200);
    @(posedge clk) #1;
    @(negedge clk);
    chk("k1_accept_after_hs", in_ready1, 1);
    chk("k1_valid_dropped", out_valid1, 0);
    @(posedge clk) #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("k1_second_valid", out_valid1, 1);
    chk("k1_second_data", out_data1, 100);

`ifdef DOT_ACC_FLUSH_EN
    @(posedge clk) #1;
    out_ready = 1'b0;
    feed(8'd50, 0); feed(8'd60, 1);
    flush = 1'b1; prod = 8'd77; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_blocks_accept", in_ready, 0);
    @(posedge clk) #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_term_idx", term_idx, 0);
    @(posedge clk) #1;
    feed(8'd1, 0); feed(8'd2, 1); feed(8'd3, 2); feed(8'd4, 3);
    flush = 1'b1;
    @(posedge clk) #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_hold_data", out_data, 10);
    chk("flush_hold_valid", out_valid, 1);
    sb.push_back(10'd10);
    @(posedge clk) #1;
    out_ready = 1'b1;
    cycles(2);
`endif

    cycles(3);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Downstream stage of the 4x4-bit array multiplier in the matrix-multiplication datapath. Accepts one 8-bit partial product per handshake and sums K consecutive products into one result-matrix element (a dot product of a row and a column). Presents the finished sum on a registered valid/ready output port and holds it until the result collector takes it.

## Interface
- K, default 4: number of products per dot product; legal range 1..16.
- ACC_W, default 10: accumulator and result width; must be at least 8 + ceil(log2(K)), which makes overflow impossible.
- IDX_W, default 2: width of term_idx; must be at least ceil(log2(K)), minimum 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- prod  input  8  product from the multiplier (its T output).
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block accepts prod this cycle.
- term_idx  output  IDX_W  index (0..K-1) of the next product expected; the upstream sequencer uses it to pick operands.
- out_data  output  ACC_W  finished dot product.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- flush  input  1  only present with DOT_ACC_FLUSH_EN; see Configuration.

## Operation
- Two states: ACCUM and HOLD.
- Reset state is ACCUM, with acc = 0, cnt = 0, out_data = 0 and out_valid = 0.
- in_ready = (state == ACCUM) and not rst. term_idx = cnt.
- Input accept = in_valid and in_ready.
- ACCUM, accept with cnt < K-1: acc <= acc + zero-extend(prod); cnt <= cnt + 1.
- ACCUM, accept with cnt == K-1:
  - out_data <= acc + prod; out_valid <= 1.
  - acc <= 0; cnt <= 0; go to HOLD.
- ACCUM with no accept: all state holds.
- HOLD: in_ready = 0. out_data and out_valid stay stable until out_ready.
- HOLD with out_ready = 1: out_valid <= 0; go to ACCUM.
- Arithmetic is unsigned. Products are zero-extended to ACC_W. No wrap or saturation is needed, because the parameter rule guarantees the sum fits.
- K = 1: every accept goes straight to HOLD with out_data = prod.
- in_valid while in HOLD is ignored. The product stays pending upstream and is not consumed.
- Reset asserted mid-operation discards the partial sum and any held result. All outputs return to their reset values immediately (asynchronously).

## Timing
- Accepting the last product at edge N gives out_valid = 1 with the correct sum right after edge N (registered, 1-cycle latency).
- Earliest next accept is the cycle after the output handshake. Peak throughput is K+1 cycles per result when out_ready is held at 1.
- No combinational path from in_valid to in_ready.
- out_ready reaches the next state only. out_valid and out_data come straight from flops.

## Configuration
- DOT_ACC_FLUSH_EN defined: adds the flush input.
  - flush = 1 in ACCUM clears acc and cnt to 0 at the next edge and blocks any accept that cycle (in_ready = 0 while flush = 1).
  - flush in HOLD has no effect; the held result is preserved.
- DOT_ACC_FLUSH_EN undefined: the port is absent. A partial sum can only be cleared by rst.

## Test plan
- K=4, ACC_W=10; feed 225, 225, 225, 225 with out_ready = 1 -> out_valid high for one cycle with out_data = 900; in_ready low that cycle; term_idx steps 0,1,2,3,0.
- Feed 1, 2, 3, 4 with out_ready = 0 for 5 cycles, in_valid held high with prod = 9 -> out_data stays 10, in_ready stays 0, the 9 is not accepted. Raise out_ready -> the next sum starts with 9.
- Randomly toggle in_valid between products 7, 0, 15, 8 -> out_data = 30, unaffected by the gaps.
- Reset after two accepted products (5, 6), then feed 1, 1, 1, 1 -> out_data = 4, with no residue from the aborted sum.
- K=1 build; feed 200 -> out_data = 200 one cycle later. A back-to-back 100 is accepted only after the output handshake.
- With DOT_ACC_FLUSH_EN: feed 50, 60, pulse flush, then feed 1, 2, 3, 4 -> out_data = 10. Pulsing flush in HOLD leaves out_data unchanged.
